// File: rtl/div.sv
// Iterative radix-2 restoring divider (signed/unsigned DIV/MOD), one quotient bit per cycle.
// Optional build macro DIV_EARLY_OUT_EN: skip the iteration when b==0 or |a|<|b|.
module div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stallreq,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_a_raw;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_bzero;

  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Magnitudes; signed min_int maps onto itself and is used as an unsigned value.
  assign w_a_abs = (signed_op && a[WIDTH-1]) ? -a : a;
  assign w_b_abs = (signed_op && b[WIDTH-1]) ? -b : b;

  // One restoring step: shift in the next dividend bit, subtract divisor if it fits.
  assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_dvs});
  assign w_sub     = WIDTH'(w_trial - {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? w_sub : WIDTH'(w_trial);
  assign w_q_mag   = {r_dvd[WIDTH-2:0], w_ge};

  // Final-step results with sign fixup; divide-by-zero bypasses the fixup.
  assign w_q_fix = r_bzero ? {WIDTH{1'b1}} : (r_sign_q ? -w_q_mag : w_q_mag);
  assign w_r_fix = r_bzero ? r_a_raw : (r_sign_r ? -w_rem_nxt : w_rem_nxt);

  // Low in DONE so the EX stage can retire the instruction.
  assign stallreq = ((r_state == S_IDLE) && in_valid) || (r_state == S_BUSY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_a_raw   <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_bzero   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_raw  <= a;
            r_dvd    <= w_a_abs;
            r_dvs    <= w_b_abs;
            r_rem    <= '0;
            r_sign_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_sign_r <= signed_op & a[WIDTH-1];
            r_bzero  <= (b == '0);
            r_cnt    <= CNT_W'(WIDTH);
`ifdef DIV_EARLY_OUT_EN
            if ((b == '0) || (w_a_abs < w_b_abs)) begin
              quotient  <= (b == '0) ? {WIDTH{1'b1}} : '0;
              remainder <= a;
              out_valid <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_BUSY;
            end
`else
            r_state <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_q_mag;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            quotient  <= w_q_fix;
            remainder <= w_r_fix;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
